// File: rtl/cache_axi_arbiter_if.sv
// Read and write channel bundles used between the cache controllers,
// the arbiter and the AXI bridge port.
interface cache_rd_if;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  modport master (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data
  );
  modport slave (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data
  );
endinterface

interface cache_wr_if;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  wr_rdy
  );
  modport slave (
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output wr_rdy
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Shares one bridge read port between icache and dcache with a single
// outstanding burst; dcache writes pass straight through.
module cache_axi_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic       clock,
  input  logic       reset,
  cache_rd_if.slave  icache_rd,
  cache_rd_if.slave  dcache_rd,
  cache_wr_if.slave  dcache_wr,
  cache_rd_if.master bridge_rd,
  cache_wr_if.master bridge_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;
  logic   lock_valid_reg, lock_valid_next;
  logic   lock_id_reg, lock_id_next;
  logic   grant;
  logic   granted_req;

  // 0 = icache, 1 = dcache. A pending unaccepted request pins the grant.
  always_comb begin
    grant = ~last_grant_reg;
    if (lock_valid_reg) begin
      grant = lock_id_reg;
    end else if (icache_rd.rd_req && !dcache_rd.rd_req) begin
      grant = 1'b0;
    end else if (dcache_rd.rd_req && !icache_rd.rd_req) begin
      grant = 1'b1;
    end else if (ARB_MODE != 0) begin
      grant = 1'b1;
    end
  end

  assign granted_req = grant ? dcache_rd.rd_req : icache_rd.rd_req;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    lock_valid_next = lock_valid_reg;
    lock_id_next    = lock_id_reg;

    bridge_rd.rd_req    = 1'b0;
    bridge_rd.rd_type   = grant ? dcache_rd.rd_type : icache_rd.rd_type;
    bridge_rd.rd_addr   = grant ? dcache_rd.rd_addr : icache_rd.rd_addr;
    icache_rd.rd_rdy    = 1'b0;
    dcache_rd.rd_rdy    = 1'b0;
    icache_rd.ret_valid = 1'b0;
    icache_rd.ret_last  = 1'b0;
    icache_rd.ret_data  = 32'd0;
    dcache_rd.ret_valid = 1'b0;
    dcache_rd.ret_last  = 1'b0;
    dcache_rd.ret_data  = 32'd0;

    case (state_reg)
      IDLE: begin
        bridge_rd.rd_req = granted_req;
        icache_rd.rd_rdy = !grant && bridge_rd.rd_rdy;
        dcache_rd.rd_rdy = grant && bridge_rd.rd_rdy;
        if (granted_req && bridge_rd.rd_rdy) begin
          state_next      = grant ? RD_D : RD_I;
          last_grant_next = grant;
          lock_valid_next = 1'b0;
        end else if (granted_req) begin
          lock_valid_next = 1'b1;
          lock_id_next    = grant;
        end else begin
          lock_valid_next = 1'b0;
        end
      end
      RD_I: begin
        icache_rd.ret_valid = bridge_rd.ret_valid;
        icache_rd.ret_last  = bridge_rd.ret_last;
        icache_rd.ret_data  = bridge_rd.ret_data;
        if (bridge_rd.ret_valid && bridge_rd.ret_last) begin
          state_next = IDLE;
        end
      end
      RD_D: begin
        dcache_rd.ret_valid = bridge_rd.ret_valid;
        dcache_rd.ret_last  = bridge_rd.ret_last;
        dcache_rd.ret_data  = bridge_rd.ret_data;
        if (bridge_rd.ret_valid && bridge_rd.ret_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The bridge shares this reset, so nothing may handshake while it is held.
    if (reset) begin
      bridge_rd.rd_req    = 1'b0;
      icache_rd.rd_rdy    = 1'b0;
      dcache_rd.rd_rdy    = 1'b0;
      icache_rd.ret_valid = 1'b0;
      icache_rd.ret_last  = 1'b0;
      dcache_rd.ret_valid = 1'b0;
      dcache_rd.ret_last  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b0;
      lock_valid_reg <= 1'b0;
      lock_id_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      lock_valid_reg <= lock_valid_next;
      lock_id_reg    <= lock_id_next;
    end
  end

  assign bridge_wr.wr_req   = dcache_wr.wr_req && !reset;
  assign bridge_wr.wr_type  = dcache_wr.wr_type;
  assign bridge_wr.wr_addr  = dcache_wr.wr_addr;
  assign bridge_wr.wr_wstrb = dcache_wr.wr_wstrb;
  assign bridge_wr.wr_data  = dcache_wr.wr_data;
  assign dcache_wr.wr_rdy   = bridge_wr.wr_rdy && !reset;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Randomized bench for cache_axi_arbiter, checked every cycle against a
// transaction-level model of the port owner, round-robin pointer and held grant.
module tb_cache_axi_arbiter;
  localparam int MODE = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cache_rd_if icache_rd ();
  cache_rd_if dcache_rd ();
  cache_rd_if bridge_rd ();
  cache_wr_if dcache_wr ();
  cache_wr_if bridge_wr ();

  cache_axi_arbiter #(.ARB_MODE(MODE)) dut (
    .clock     (clock),
    .reset     (reset),
    .icache_rd (icache_rd),
    .dcache_rd (dcache_rd),
    .dcache_wr (dcache_wr),
    .bridge_rd (bridge_rd),
    .bridge_wr (bridge_wr)
  );

  typedef struct packed {
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         i_rd_rdy;
    logic         d_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_last;
    logic [31:0]  i_ret_data;
    logic         d_ret_valid;
    logic         d_ret_last;
    logic [31:0]  d_ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         d_wr_rdy;
  } outs_t;

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner of the port (0 none, 1 icache, 2 dcache), who won last
  // (0 icache, 1 dcache) and which requester is being held (-1 none).
  int m_owner = 0;
  int m_last  = 0;
  int m_held  = -1;

  function automatic int pick_winner();
    if (m_held >= 0) return m_held;
    if (icache_rd.rd_req && !dcache_rd.rd_req) return 0;
    if (dcache_rd.rd_req && !icache_rd.rd_req) return 1;
    if (MODE == 1) return 1;
    return 1 - m_last;
  endfunction

  function automatic void expect_outs(output outs_t e, output outs_t m);
    int   g;
    logic has_g;
    e = '0;
    m = '1;
    e.wr_type  = dcache_wr.wr_type;
    e.wr_addr  = dcache_wr.wr_addr;
    e.wr_wstrb = dcache_wr.wr_wstrb;
    e.wr_data  = dcache_wr.wr_data;
    e.wr_req   = dcache_wr.wr_req && !reset;
    e.d_wr_rdy = bridge_wr.wr_rdy && !reset;
    if (reset) begin
      m.rd_type = '0; m.rd_addr = '0; m.i_ret_data = '0; m.d_ret_data = '0;
      return;
    end
    if (m_owner == 0) begin
      has_g = (m_held >= 0) || icache_rd.rd_req || dcache_rd.rd_req;
      g = pick_winner();
      if (has_g) begin
        e.rd_req   = (g == 1) ? dcache_rd.rd_req  : icache_rd.rd_req;
        e.rd_type  = (g == 1) ? dcache_rd.rd_type : icache_rd.rd_type;
        e.rd_addr  = (g == 1) ? dcache_rd.rd_addr : icache_rd.rd_addr;
        e.i_rd_rdy = (g == 0) && bridge_rd.rd_rdy;
        e.d_rd_rdy = (g == 1) && bridge_rd.rd_rdy;
      end else begin
        m.rd_type = '0; m.rd_addr = '0; m.i_rd_rdy = 1'b0; m.d_rd_rdy = 1'b0;
      end
    end else begin
      m.rd_type = '0; m.rd_addr = '0;
      if (m_owner == 1) begin
        e.i_ret_valid = bridge_rd.ret_valid;
        e.i_ret_last  = bridge_rd.ret_last;
        e.i_ret_data  = bridge_rd.ret_data;
      end else begin
        e.d_ret_valid = bridge_rd.ret_valid;
        e.d_ret_last  = bridge_rd.ret_last;
        e.d_ret_data  = bridge_rd.ret_data;
      end
    end
  endfunction

  function automatic void model_update();
    int   g;
    logic r;
    if (reset) begin
      m_owner = 0; m_last = 0; m_held = -1;
    end else if (m_owner == 0) begin
      g = pick_winner();
      r = (g == 1) ? dcache_rd.rd_req : icache_rd.rd_req;
      if (r && bridge_rd.rd_rdy) begin
        m_owner = g + 1; m_last = g; m_held = -1;
      end else if (r) begin
        m_held = g;
      end else begin
        m_held = -1;
      end
    end else if (bridge_rd.ret_valid && bridge_rd.ret_last) begin
      m_owner = 0;
    end
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.rd_req      = bridge_rd.rd_req;
    o.rd_type     = bridge_rd.rd_type;
    o.rd_addr     = bridge_rd.rd_addr;
    o.i_rd_rdy    = icache_rd.rd_rdy;
    o.d_rd_rdy    = dcache_rd.rd_rdy;
    o.i_ret_valid = icache_rd.ret_valid;
    o.i_ret_last  = icache_rd.ret_last;
    o.i_ret_data  = icache_rd.ret_data;
    o.d_ret_valid = dcache_rd.ret_valid;
    o.d_ret_last  = dcache_rd.ret_last;
    o.d_ret_data  = dcache_rd.ret_data;
    o.wr_req      = bridge_wr.wr_req;
    o.wr_type     = bridge_wr.wr_type;
    o.wr_addr     = bridge_wr.wr_addr;
    o.wr_wstrb    = bridge_wr.wr_wstrb;
    o.wr_data     = bridge_wr.wr_data;
    o.d_wr_rdy    = dcache_wr.wr_rdy;
    return o;
  endfunction

  task automatic settle(output outs_t e, output outs_t m, output outs_t o);
    #7;
    expect_outs(e, m);
    o = observe();
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    icache_rd.rd_req = 1'b0; icache_rd.rd_type = 3'd0; icache_rd.rd_addr = 32'd0;
    dcache_rd.rd_req = 1'b0; dcache_rd.rd_type = 3'd0; dcache_rd.rd_addr = 32'd0;
    bridge_rd.rd_rdy = 1'b0; bridge_rd.ret_valid = 1'b0; bridge_rd.ret_last = 1'b0;
    bridge_rd.ret_data = 32'd0;
    dcache_wr.wr_req = 1'b0; dcache_wr.wr_type = 3'd0; dcache_wr.wr_addr = 32'd0;
    dcache_wr.wr_wstrb = 4'd0; dcache_wr.wr_data = 128'd0; bridge_wr.wr_rdy = 1'b0;
  endtask

  // Drives one burst to owner (1 icache, 2 dcache) with optional idle gaps.
  task automatic run_burst(input int nbeats, input int owner, input int max_gap,
                           input logic [31:0] base, input string tag);
    outs_t e, m, o;
    logic [33:0] got, want;
    int gaps;
    for (int b = 0; b < nbeats; b++) begin
      gaps = $urandom_range(0, max_gap);
      for (int g = 0; g < gaps; g++) begin
        bridge_rd.ret_valid = 1'b0;
        bridge_rd.ret_last  = 1'($urandom_range(0, 1));
        bridge_rd.ret_data  = $urandom;
        settle(e, m, o);
        n_checks++;
        if ((o & m) !== (e & m)) begin
          n_errors++;
          $display("FAIL %s_gap%0d_%0d: got %h want %h", tag, b, g, o & m, e & m);
        end
        tick();
      end
      bridge_rd.ret_valid = 1'b1;
      bridge_rd.ret_last  = (b == nbeats - 1);
      bridge_rd.ret_data  = base + 32'(b);
      settle(e, m, o);
      n_checks++;
      if ((o & m) !== (e & m)) begin
        n_errors++;
        $display("FAIL %s_beat%0d: got %h want %h", tag, b, o & m, e & m);
      end
      got  = (owner == 1) ? {o.i_ret_valid, o.d_ret_valid, o.i_ret_data}
                          : {o.d_ret_valid, o.i_ret_valid, o.d_ret_data};
      want = {1'b1, 1'b0, base + 32'(b)};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL %s_route%0d: got %h want %h", tag, b, got, want);
      end
      n_checks++;
      if ({o.rd_req, o.i_rd_rdy, o.d_rd_rdy} !== 3'b000) begin
        n_errors++;
        $display("FAIL %s_busy%0d: got req/irdy/drdy %b want 000", tag, b,
                 {o.rd_req, o.i_rd_rdy, o.d_rd_rdy});
      end
      tick();
    end
    bridge_rd.ret_valid = 1'b0;
    bridge_rd.ret_last  = 1'b0;
  endtask

  task automatic test_reset();
    outs_t e, m, o;
    reset = 1'b1;
    icache_rd.rd_req = 1'b1; dcache_rd.rd_req = 1'b1; bridge_rd.rd_rdy = 1'b1;
    bridge_rd.ret_valid = 1'b1; bridge_rd.ret_last = 1'b1;
    dcache_wr.wr_req = 1'b1; bridge_wr.wr_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle(e, m, o);
      n_checks++;
      if ({o.rd_req, o.i_rd_rdy, o.d_rd_rdy, o.i_ret_valid, o.i_ret_last,
           o.d_ret_valid, o.d_ret_last, o.wr_req, o.d_wr_rdy} !== 9'd0) begin
        n_errors++;
        $display("FAIL reset_force%0d: got %h want 000", c,
                 {o.rd_req, o.i_rd_rdy, o.d_rd_rdy, o.i_ret_valid, o.i_ret_last,
                  o.d_ret_valid, o.d_ret_last, o.wr_req, o.d_wr_rdy});
      end
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m)) begin
      n_errors++;
      $display("FAIL reset_idle: got %h want %h", o & m, e & m);
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_icache();
    outs_t e, m, o;
    icache_rd.rd_req = 1'b1; icache_rd.rd_addr = 32'h1C00_0000;
    icache_rd.rd_type = 3'($urandom_range(0, 7)); bridge_rd.rd_rdy = 1'b1;
    settle(e, m, o);
    n_checks++;
    if ({o.rd_req, o.rd_addr, o.i_rd_rdy} !== {1'b1, 32'h1C00_0000, 1'b1}) begin
      n_errors++;
      $display("FAIL single_req: got %h want %h", {o.rd_req, o.rd_addr, o.i_rd_rdy},
               {1'b1, 32'h1C00_0000, 1'b1});
    end
    tick();
    icache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    run_burst(4, 1, 0, 32'hA0, "single");
    dcache_rd.rd_req = 1'b1; dcache_rd.rd_addr = $urandom;
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m) || o.rd_req !== 1'b1) begin
      n_errors++;
      $display("FAIL single_back_idle: got %h want %h", o & m, e & m);
    end
    tick();
    dcache_rd.rd_req = 1'b0;
    tick();
    $display("test_single_icache done");
  endtask

  task automatic test_round_robin();
    outs_t e, m, o;
    logic [31:0] ai, ad, want_addr;
    int winner;
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      winner = (k == 1) ? 1 : 2;
      ai = $urandom; ad = $urandom;
      icache_rd.rd_req = 1'b1; icache_rd.rd_addr = ai;
      dcache_rd.rd_req = 1'b1; dcache_rd.rd_addr = ad;
      bridge_rd.rd_rdy = 1'b1;
      settle(e, m, o);
      want_addr = (winner == 1) ? ai : ad;
      n_checks++;
      if ((o & m) !== (e & m) || o.rd_addr !== want_addr) begin
        n_errors++;
        $display("FAIL rr_tie%0d: got addr %h want %h", k, o.rd_addr, want_addr);
      end
      tick();
      if (winner == 1) icache_rd.rd_req = 1'b0;
      else dcache_rd.rd_req = 1'b0;
      run_burst($urandom_range(1, 4), winner, 1, $urandom, $sformatf("rr%0d", k));
    end
    icache_rd.rd_req = 1'b0; dcache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_lock();
    outs_t e, m, o;
    logic [31:0] ai, ad;
    ai = $urandom; ad = $urandom;
    for (int c = 0; c < 4; c++) begin
      dcache_rd.rd_req = 1'b1; dcache_rd.rd_addr = ad;
      icache_rd.rd_req = (c >= 1); icache_rd.rd_addr = ai;
      bridge_rd.rd_rdy = (c == 3);
      settle(e, m, o);
      n_checks++;
      if ((o & m) !== (e & m) || o.rd_addr !== ad || o.i_rd_rdy !== 1'b0) begin
        n_errors++;
        $display("FAIL lock_hold%0d: got addr %h irdy %b want %h 0", c, o.rd_addr,
                 o.i_rd_rdy, ad);
      end
      tick();
    end
    dcache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    run_burst(2, 2, 0, $urandom, "lock_d");
    // icache now granted but stalled, then it withdraws while dcache asks
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m) || o.rd_addr !== ai) begin
      n_errors++;
      $display("FAIL lock_i_grant: got addr %h want %h", o.rd_addr, ai);
    end
    tick();
    icache_rd.rd_req = 1'b0; dcache_rd.rd_req = 1'b1; bridge_rd.rd_rdy = 1'b1;
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m) || {o.rd_req, o.d_rd_rdy} !== 2'b00) begin
      n_errors++;
      $display("FAIL lock_drop: got req/drdy %b want 00", {o.rd_req, o.d_rd_rdy});
    end
    tick();
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m) || {o.rd_req, o.d_rd_rdy, o.rd_addr} !== {2'b11, ad}) begin
      n_errors++;
      $display("FAIL lock_release: got %h want %h", {o.rd_req, o.d_rd_rdy, o.rd_addr},
               {2'b11, ad});
    end
    tick();
    dcache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    run_burst(1, 2, 1, $urandom, "lock_d2");
    $display("test_lock done");
  endtask

  task automatic test_midburst();
    outs_t e, m, o;
    logic [31:0] ai;
    ai = $urandom;
    dcache_rd.rd_req = 1'b1; dcache_rd.rd_addr = $urandom; bridge_rd.rd_rdy = 1'b1;
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m)) begin
      n_errors++;
      $display("FAIL mid_accept: got %h want %h", o & m, e & m);
    end
    tick();
    dcache_rd.rd_req = 1'b0;
    icache_rd.rd_req = 1'b1; icache_rd.rd_addr = ai;
    run_burst(3, 2, 2, $urandom, "mid_d");
    settle(e, m, o);
    n_checks++;
    if ({o.rd_req, o.i_rd_rdy, o.rd_addr} !== {2'b11, ai}) begin
      n_errors++;
      $display("FAIL mid_next: got %h want %h", {o.rd_req, o.i_rd_rdy, o.rd_addr},
               {2'b11, ai});
    end
    tick();
    icache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    run_burst(2, 1, 1, $urandom, "mid_i");
    $display("test_midburst done");
  endtask

  task automatic test_write_passthrough();
    outs_t e, m, o;
    logic [127:0] wdata;
    logic [31:0]  rdata;
    icache_rd.rd_req = 1'b1; icache_rd.rd_addr = $urandom; bridge_rd.rd_rdy = 1'b1;
    tick();
    icache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wdata = {$urandom, $urandom, $urandom, 32'hDEAD_BEEF};
      rdata = $urandom;
      dcache_wr.wr_req = 1'b1; dcache_wr.wr_addr = 32'h0000_1000;
      dcache_wr.wr_wstrb = 4'hF; dcache_wr.wr_data = wdata;
      dcache_wr.wr_type = 3'($urandom_range(0, 7));
      bridge_wr.wr_rdy = (b != 2);
      bridge_rd.ret_valid = 1'b1; bridge_rd.ret_last = (b == 3);
      bridge_rd.ret_data = rdata;
      settle(e, m, o);
      n_checks++;
      if ((o & m) !== (e & m) ||
          {o.wr_req, o.wr_addr, o.wr_wstrb, o.wr_data, o.d_wr_rdy} !==
          {1'b1, 32'h0000_1000, 4'hF, wdata, (b != 2)} ||
          {o.i_ret_valid, o.i_ret_data} !== {1'b1, rdata}) begin
        n_errors++;
        $display("FAIL wr_pass%0d: got %h want %h", b, o & m, e & m);
      end
      tick();
    end
    idle_inputs();
    tick();
    $display("test_write_passthrough done");
  endtask

  task automatic test_reset_midburst();
    outs_t e, m, o;
    icache_rd.rd_req = 1'b1; icache_rd.rd_addr = $urandom; bridge_rd.rd_rdy = 1'b1;
    tick();
    icache_rd.rd_req = 1'b0; bridge_rd.rd_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bridge_rd.ret_valid = 1'b1; bridge_rd.ret_last = 1'b0; bridge_rd.ret_data = $urandom;
      tick();
    end
    reset = 1'b1;
    icache_rd.rd_req = 1'b1; dcache_rd.rd_req = 1'b1; bridge_rd.rd_rdy = 1'b1;
    bridge_rd.ret_valid = 1'b1; bridge_rd.ret_last = 1'b1;
    dcache_wr.wr_req = 1'b1; bridge_wr.wr_rdy = 1'b1;
    settle(e, m, o);
    n_checks++;
    if ({o.rd_req, o.i_rd_rdy, o.d_rd_rdy, o.i_ret_valid, o.i_ret_last,
         o.d_ret_valid, o.d_ret_last, o.wr_req, o.d_wr_rdy} !== 9'd0) begin
      n_errors++;
      $display("FAIL rstmid_force: got %h want 000",
               {o.rd_req, o.i_rd_rdy, o.d_rd_rdy, o.i_ret_valid, o.i_ret_last,
                o.d_ret_valid, o.d_ret_last, o.wr_req, o.d_wr_rdy});
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    // stray beat and an immediate dcache accept in the first cycle out of reset
    bridge_rd.ret_valid = 1'b1; bridge_rd.ret_last = 1'b1; bridge_rd.ret_data = $urandom;
    dcache_rd.rd_req = 1'b1; dcache_rd.rd_addr = $urandom; bridge_rd.rd_rdy = 1'b1;
    settle(e, m, o);
    n_checks++;
    if ((o & m) !== (e & m) ||
        {o.i_ret_valid, o.d_ret_valid, o.rd_req, o.d_rd_rdy} !== 4'b0011) begin
      n_errors++;
      $display("FAIL rstmid_stray: got %b want 0011",
               {o.i_ret_valid, o.d_ret_valid, o.rd_req, o.d_rd_rdy});
    end
    tick();
    idle_inputs();
    run_burst(2, 2, 1, $urandom, "rstmid_d");
    $display("test_reset_midburst done");
  endtask

  task automatic test_random();
    outs_t e, m, o;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      icache_rd.rd_req = ($urandom_range(0, 99) < 60);
      icache_rd.rd_addr = $urandom; icache_rd.rd_type = 3'($urandom_range(0, 7));
      dcache_rd.rd_req = ($urandom_range(0, 99) < 60);
      dcache_rd.rd_addr = $urandom; dcache_rd.rd_type = 3'($urandom_range(0, 7));
      bridge_rd.rd_rdy = ($urandom_range(0, 99) < 50);
      if (m_owner != 0) begin
        bridge_rd.ret_valid = ($urandom_range(0, 99) < 60);
        bridge_rd.ret_last  = ($urandom_range(0, 99) < 30);
      end else begin
        bridge_rd.ret_valid = ($urandom_range(0, 99) < 10);
        bridge_rd.ret_last  = 1'($urandom_range(0, 1));
      end
      bridge_rd.ret_data = $urandom;
      dcache_wr.wr_req = 1'($urandom_range(0, 1)); dcache_wr.wr_addr = $urandom;
      dcache_wr.wr_type = 3'($urandom_range(0, 7)); dcache_wr.wr_wstrb = 4'($urandom_range(0, 15));
      dcache_wr.wr_data = {$urandom, $urandom, $urandom, $urandom};
      bridge_wr.wr_rdy = 1'($urandom_range(0, 1));
      settle(e, m, o);
      n_checks++;
      if ((o & m) !== (e & m)) begin
        n_errors++;
        $display("FAIL random%0d: got %h want %h", c, o & m, e & m);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    idle_inputs();
    @(posedge clock);
    #1;
    test_reset();
    test_single_icache();
    test_round_robin();
    test_lock();
    test_midburst();
    test_write_passthrough();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares one cache-side AXI bridge port between the instruction cache (read-only) and the data cache (read/write). Arbitrates read requests, keeps a granted request stable until accepted, and permits exactly one outstanding read burst. Steers return beats to the owner of that burst. Sits between the two cache controllers and the AXI bridge; dcache writes pass through unarbitrated.

## Interface
- `ARB_MODE`, default 0: 0 = round-robin between icache and dcache reads; 1 = fixed priority, dcache wins.
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `i_rd_req`  in  1  icache read request.
- `i_rd_type`  in  3  icache read type.
- `i_rd_addr`  in  32  icache read address.
- `i_rd_rdy`  out  1  icache request accepted by the bridge.
- `i_ret_valid`, `i_ret_last`  out  1 each  return beat and last flag for icache.
- `i_ret_data`  out  32  return data for icache.
- `d_rd_req`, `d_rd_type`, `d_rd_addr`, `d_rd_rdy`, `d_ret_valid`, `d_ret_last`, `d_ret_data`: same directions and widths as the `i_` set, for the dcache.
- `d_wr_req`  in  1  dcache write request.
- `d_wr_type`  in  3  write type.
- `d_wr_addr`  in  32  write address.
- `d_wr_wstrb`  in  4  write strobe.
- `d_wr_data`  in  128  write data.
- `d_wr_rdy`  out  1  write accepted.
- `rd_req`, `rd_type`, `rd_addr`  out  1/3/32  bridge read request.
- `rd_rdy`  in  1  bridge read accept.
- `ret_valid`, `ret_last`, `ret_data`  in  1/1/32  bridge return beats.
- `wr_req`, `wr_type`, `wr_addr`, `wr_wstrb`, `wr_data`  out  1/3/32/4/128  bridge write request.
- `wr_rdy`  in  1  bridge write accept.

## Operation
- State machine: IDLE, RD_I (icache burst outstanding), RD_D (dcache burst outstanding).
- Registers: `state`, `last_grant` (0 = icache, 1 = dcache), `lock_valid`, `lock_id`.
- Grant in IDLE:
  - If `lock_valid` is set, grant = `lock_id`.
  - Otherwise, with a single requester, that requester is granted.
  - With both requesting: ARB_MODE=0 grants the requester ≠ `last_grant`. ARB_MODE=1 grants the dcache.
- In IDLE, `rd_req` equals the granted requester's `*_rd_req`; `rd_type` and `rd_addr` are muxed from the granted requester.
- The granted requester's `*_rd_rdy` equals `rd_rdy`. The other requester's `*_rd_rdy` is 0.
- Acceptance is `rd_req && rd_rdy` in IDLE. On acceptance:
  - state becomes RD_I or RD_D;
  - `last_grant` becomes the granted id;
  - `lock_valid` is cleared.
- Granted but not accepted (`rd_req && !rd_rdy`): set `lock_valid` and `lock_id` = granted id. Grant cannot switch while the requester holds `*_rd_req`.
- If the locked requester drops its request, clear `lock_valid` the next cycle.
- In RD_I / RD_D:
  - `rd_req` = 0 and both `*_rd_rdy` = 0.
  - Bridge `ret_valid`, `ret_last` and `ret_data` route to the owner only. The non-owner's `*_ret_valid` and `*_ret_last` are 0; its `*_ret_data` is 0.
- `ret_valid && ret_last` in RD_x moves state to IDLE on the next edge.
- `ret_valid` seen in IDLE is dropped and not routed.
- Writes are a pure passthrough in every state: `wr_*` = `d_wr_*`, `d_wr_rdy` = `wr_rdy`.
- Reset:
  - state = IDLE, `last_grant` = 0 (dcache wins the first tie), `lock_valid` = 0.
  - While `reset` is high, `rd_req`, `wr_req`, both `*_rd_rdy`, `d_wr_rdy`, both `*_ret_valid` and both `*_ret_last` are forced to 0.
- Reset mid-burst: abandon the burst and return to IDLE. The bridge is reset by the same signal.

## Timing
- Grant and request forwarding are combinational: a request present in IDLE reaches `rd_req` in the same cycle, with 0-cycle added latency.
- A burst occupies the port from the accept edge through the edge after the `ret_last` beat.
- A new read may be accepted in the first IDLE cycle after that, so there is a 1-cycle bubble between bursts.
- `ret_*` routing is combinational, with 0-cycle latency.
- The write path is fully combinational and stateless.
- After `reset` deasserts, the first acceptance can happen in the same cycle.

## Test plan
- Single icache read:
  - Stimulus: `i_rd_req`, addr 0x1C000000, `rd_rdy`=1, then 4 beats 0xA0..0xA3 with last on the 4th.
  - Required: `rd_addr`=0x1C000000, `i_ret_valid` ×4 with matching data, `d_ret_valid` stays 0, state returns to IDLE.
- Simultaneous requests after reset, ARB_MODE=0:
  - Required: dcache is granted first (`last_grant`=0); after its burst the icache is granted; the next tie goes to the dcache again.
- Lock stability:
  - Stimulus: dcache requests with `rd_rdy`=0 for 3 cycles while the icache requests from cycle 2.
  - Required: `rd_addr` stays the dcache address until acceptance; `i_rd_rdy` stays 0.
- Mid-burst request:
  - Stimulus: icache requests during an RD_D burst.
  - Required: `rd_req`=0 until `ret_last`; the icache is accepted 1 cycle after the burst ends.
- Write passthrough:
  - Stimulus: `d_wr_req` with addr 0x00001000, wstrb 0xF, data 0x...DEADBEEF during RD_I, `wr_rdy`=1.
  - Required: `wr_*` mirrors the inputs in the same cycle and `d_wr_rdy`=1; the read burst is unaffected.
- Reset mid-burst:
  - Stimulus: assert `reset` after beat 2 of an RD_I burst.
  - Required: all `rd_req`/`*_rdy`/`*_ret_valid`/`*_ret_last`/`wr_req` outputs are 0 during reset; state is IDLE after reset; a stray `ret_valid` afterwards is not routed.
